// File: rtl/timer_entry_register_if.sv
// Keypad-entry bus between the encoder/timer side (master) and the entry stage (slave).
// Port names follow the keypad encoder and countdown timer signal names.
interface timer_entry_register_if;
  logic [3:0]  D;
  logic        valid;
  logic        start;
  logic        clear;
  logic        busy;
  logic        enablen;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic        load;

  modport master (
    output D, valid, start, clear, busy,
    input  enablen, entry, digit_count, key_strobe, load
  );

  modport slave (
    input  D, valid, start, clear, busy,
    output enablen, entry, digit_count, key_strobe, load
  );
endinterface

// File: rtl/timer_entry_register.sv
// Keypad-to-timer entry stage: debounces encoded digits, shifts them into a 4-digit BCD
// buffer and hands the buffer to the countdown timer with a one-cycle load pulse.
module timer_entry_register #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  clearn,
  timer_entry_register_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    ACCEPT,
    WAIT_REL,
    REL_DB
  } state_e;

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       entry_q, entry_d;
  logic [2:0]        count_q, count_d;
  logic              key_strobe_q, key_strobe_d;
  logic              load_q, load_d;
  logic              enablen_q, enablen_d;
  logic              start_q, start_d;

  logic press;
  logic start_edge;
  logic accept;

  // NOTE: combinational next-state logic uses blocking assignments, and every target gets a
  // default at the top so no path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    press      = !bus.valid && (bus.D <= 4'd9);
    start_edge = bus.start && !start_q;
    accept     = 1'b0;

    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    entry_d      = entry_q;
    count_d      = count_q;
    key_strobe_d = 1'b0;
    load_d       = 1'b0;
    enablen_d    = bus.busy;
    start_d      = bus.start;

    unique case (state_q)
      IDLE: begin
        if (press) begin
          cand_d  = bus.D;
          cnt_d   = '0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!press || (bus.D != cand_q)) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ACCEPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACCEPT: begin
        accept  = 1'b1;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!press) begin
          cnt_d   = '0;
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (press) begin
          state_d = WAIT_REL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A running timer owns the keypad: abandon any debounce in progress.
    if (bus.busy) begin
      state_d = IDLE;
      cnt_d   = '0;
      accept  = 1'b0;
    end

    // Clear beats the post-load wipe, which beats a digit accept; a dropped digit gives no strobe.
    if (bus.clear || load_q) begin
      entry_d = '0;
      count_d = '0;
    end else begin
      if (accept) begin
        entry_d      = {entry_q[11:0], cand_q};
        count_d      = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
        key_strobe_d = 1'b1;
      end
      // Uses the post-accept count so a start coinciding with ACCEPT loads the new digit.
      if (start_edge && !bus.busy && (count_d != 3'd0)) begin
        load_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      entry_q      <= '0;
      count_q      <= '0;
      key_strobe_q <= 1'b0;
      load_q       <= 1'b0;
      enablen_q    <= 1'b1;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      entry_q      <= entry_d;
      count_q      <= count_d;
      key_strobe_q <= key_strobe_d;
      load_q       <= load_d;
      enablen_q    <= enablen_d;
      start_q      <= start_d;
    end
  end

  assign bus.enablen     = enablen_q;
  assign bus.entry       = entry_q;
  assign bus.digit_count = count_q;
  assign bus.key_strobe  = key_strobe_q;
  assign bus.load        = load_q;

endmodule
